// File: rtl/fetch_ctrl.sv
// Front-end fetch control: PC update, IF/ID and ID/EX register controls,
// redirect/hazard/wait-state resolution and stall/flush performance counters.
module fetch_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_bne,
    input  logic             ex_zero,
    input  logic             ex_jump,
    input  logic [31:0]      ex_br_tgt,
    input  logic [31:0]      ex_jmp_tgt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             pc_src,
    output logic [31:0]      pc_tgt,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        FLUSH
    } state_t;

    localparam logic [2:0]       FE      = 3'(FLUSH_EXTRA);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [2:0]  fcnt_q, fcnt_d;

    logic        taken;
    logic        lu_hazard;
    logic [31:0] target;
    logic        do_redir;
    logic [31:0] redir_tgt;

    assign taken  = ex_valid & (ex_jump | (ex_branch & (ex_zero ^ ex_bne)));
    assign target = ex_jump ? ex_jmp_tgt : ex_br_tgt;

    assign lu_hazard = ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        fcnt_d       = fcnt_q;
        imem_req     = 1'b1;
        pc_en        = imem_ready;
        pc_src       = 1'b0;
        pc_tgt       = 32'd0;
        if_id_en     = 1'b1;
        if_id_flush  = ~imem_ready;
        id_ex_bubble = 1'b0;
        do_redir     = 1'b0;
        redir_tgt    = target;

        unique case (state_q)
            RUN: begin
                if (taken) begin
                    do_redir = 1'b1;
                end else if (lu_hazard) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    if_id_flush  = 1'b0;
                end else if (!imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                if (taken && !pend_q) begin
                    pend_d       = 1'b1;
                    pend_tgt_d   = target;
                    id_ex_bubble = 1'b1;
                end
                if (imem_ready) begin
                    if (pend_q || taken) begin
                        do_redir  = 1'b1;
                        redir_tgt = pend_q ? pend_tgt_q : target;
                    end else begin
                        // The returning word is the one we waited for; keep it.
                        pc_en       = 1'b1;
                        if_id_flush = 1'b0;
                        state_d     = RUN;
                    end
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                if (taken) begin
                    do_redir = 1'b1;
                end else if (imem_ready) begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (do_redir) begin
            pc_en        = 1'b1;
            pc_src       = 1'b1;
            pc_tgt       = redir_tgt;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pend_d       = 1'b0;
            fcnt_d       = FE;
            state_d      = (FE == 3'd0) ? RUN : FLUSH;
        end

        if (rst) begin
            imem_req     = 1'b0;
            pc_en        = 1'b0;
            pc_src       = 1'b0;
            pc_tgt       = 32'd0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'd0;
            fcnt_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (if_id_flush && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios then random traffic,
// checked against a cycle-level reference model of the fetch rules.
module tb_fetch_ctrl;

    localparam int FE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        ex_valid, ex_branch, ex_bne, ex_zero, ex_jump;
    logic [31:0] ex_br_tgt, ex_jmp_tgt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        id_uses_rt;

    logic        imem_req, pc_en, pc_src, if_id_en, if_id_flush, id_ex_bubble;
    logic [31:0] pc_tgt;
    logic [15:0] stall_cnt, flush_cnt;

    logic        imem_req4, pc_en4, pc_src4, if_id_en4, if_id_flush4, id_ex_bubble4;
    logic [31:0] pc_tgt4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.FLUSH_EXTRA(FE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_bne(ex_bne),
        .ex_zero(ex_zero), .ex_jump(ex_jump), .ex_br_tgt(ex_br_tgt),
        .ex_jmp_tgt(ex_jmp_tgt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .pc_en(pc_en), .pc_src(pc_src), .pc_tgt(pc_tgt), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_ctrl #(.FLUSH_EXTRA(FE), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .imem_req(imem_req4), .imem_ready(imem_ready),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_bne(ex_bne),
        .ex_zero(ex_zero), .ex_jump(ex_jump), .ex_br_tgt(ex_br_tgt),
        .ex_jmp_tgt(ex_jmp_tgt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .pc_en(pc_en4), .pc_src(pc_src4), .pc_tgt(pc_tgt4), .if_id_en(if_id_en4),
        .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        logic        req, en, src, ifen, flush, bub;
        logic [31:0] tgt;
        bit          cnt_ok;
        int          stall, flushes;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    bit          m_wait;
    int          m_flush_left;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    int          m_stall, m_flushc;
    bit          m_known = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("imem_req", 32'(imem_req), 32'(e.req));
            chk("pc_en", 32'(pc_en), 32'(e.en));
            chk("pc_src", 32'(pc_src), 32'(e.src));
            chk("pc_tgt", pc_tgt, e.tgt);
            chk("if_id_en", 32'(if_id_en), 32'(e.ifen));
            chk("if_id_flush", 32'(if_id_flush), 32'(e.flush));
            chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
            chk("pc_en_w4", 32'(pc_en4), 32'(e.en));
            if (e.cnt_ok) begin
                chk("stall_cnt", 32'(stall_cnt), 32'(sat(e.stall, 65535)));
                chk("flush_cnt", 32'(flush_cnt), 32'(sat(e.flushes, 65535)));
                chk("stall_cnt_w4", 32'(stall_cnt4), 32'(sat(e.stall, 15)));
                chk("flush_cnt_w4", 32'(flush_cnt4), 32'(sat(e.flushes, 15)));
            end
        end
    end

    // Compute this cycle's expected outputs, queue them, advance the model.
    task automatic step();
        exp_t        e;
        bit          tk, lu, redir, pend_before;
        logic [31:0] ta, ra;
        tk = ex_valid && (ex_jump || (ex_branch && (ex_zero != ex_bne)));
        ta = ex_jump ? ex_jmp_tgt : ex_br_tgt;
        lu = ex_valid && ex_mem_read && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        e.req = 1; e.en = 0; e.src = 0; e.tgt = 0;
        e.ifen = 1; e.flush = 0; e.bub = 0;
        e.cnt_ok = m_known; e.stall = m_stall; e.flushes = m_flushc;
        redir = 0; ra = ta;
        if (rst) begin
            e.req = 0; e.ifen = 0; e.flush = 1; e.bub = 1;
            m_wait = 0; m_flush_left = 0; m_pend = 0;
            m_stall = 0; m_flushc = 0; m_known = 1;
        end else begin
            if (m_wait) begin
                pend_before = m_pend;
                e.flush = 1;
                if (tk && !pend_before) e.bub = 1;
                if (imem_ready) begin
                    if (pend_before || tk) begin
                        redir = 1;
                        ra = pend_before ? m_pend_addr : ta;
                    end else begin
                        e.en = 1; e.flush = 0; m_wait = 0;
                    end
                end else if (tk && !pend_before) begin
                    m_pend = 1; m_pend_addr = ta;
                end
            end else if (tk) begin
                redir = 1;
            end else if (m_flush_left > 0) begin
                e.en = imem_ready; e.flush = 1;
                if (imem_ready) m_flush_left--;
            end else if (lu) begin
                e.ifen = 0; e.bub = 1;
            end else if (!imem_ready) begin
                e.flush = 1; m_wait = 1;
            end else begin
                e.en = 1;
            end
            if (redir) begin
                e.en = 1; e.src = 1; e.tgt = ra; e.flush = 1; e.bub = 1;
                m_wait = 0; m_pend = 0; m_flush_left = FE;
            end
            if (!e.en) m_stall++;
            if (e.flush) m_flushc++;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 0; imem_ready = 1;
        ex_valid = 0; ex_branch = 0; ex_bne = 0; ex_zero = 0; ex_jump = 0;
        ex_br_tgt = 0; ex_jmp_tgt = 0; ex_mem_read = 0;
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    endtask

    task automatic rand_in();
        imem_ready  = ($urandom_range(0, 3) != 0);
        ex_valid    = $urandom_range(0, 1);
        ex_branch   = ($urandom_range(0, 9) < 3);
        ex_bne      = $urandom_range(0, 1);
        ex_zero     = $urandom_range(0, 1);
        ex_jump     = ($urandom_range(0, 9) == 0);
        ex_br_tgt   = $urandom;
        ex_jmp_tgt  = $urandom;
        ex_mem_read = ($urandom_range(0, 9) < 3);
        ex_rt       = 5'($urandom_range(0, 3));
        id_rs       = 5'($urandom_range(0, 3));
        id_rt       = 5'($urandom_range(0, 3));
        id_uses_rt  = $urandom_range(0, 1);
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            rand_in();
            rst = 1;
            step();
        end
        set_idle();
    endtask

    task automatic idle(int n);
        set_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        set_idle();
        @(posedge clk);
        #1;

        do_reset(3);
        idle(1);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);

        // Taken beq
        ex_valid = 1; ex_branch = 1; ex_bne = 0; ex_zero = 1; ex_br_tgt = 32'h40;
        step();
        idle(3);
        chk("beq_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("beq_stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use, then the same with rt=0
        do_reset(1);
        ex_valid = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        step();
        idle(2);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        ex_valid = 1; ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        step();
        idle(1);
        chk("lu_rt0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Memory wait of four cycles
        do_reset(1);
        imem_ready = 0;
        for (int i = 0; i < 4; i++) step();
        idle(2);
        chk("wait_stall_cnt", 32'(stall_cnt), 32'd4);

        // Jump during wait, delivered on the ready cycle
        do_reset(1);
        imem_ready = 0;
        step();
        step();
        ex_valid = 1; ex_jump = 1; ex_jmp_tgt = 32'h100;
        step();
        ex_valid = 0; ex_jump = 0;
        step();
        imem_ready = 1;
        #1;
        chk("wait_redir_src", 32'(pc_src), 32'd1);
        chk("wait_redir_tgt", pc_tgt, 32'h100);
        step();
        idle(3);

        // Counter saturation
        do_reset(1);
        imem_ready = 0;
        for (int i = 0; i < 20; i++) step();
        idle(1);
        chk("sat_stall_cnt_w4", 32'(stall_cnt4), 32'd15);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd20);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        idle(4);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
